// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } owner_e;

  localparam int BE_W      = 4;
  localparam int DATA_W    = 32;
  localparam int MEM_BYTES = 16384;
  localparam int MEM_AW_DEF = $clog2(MEM_BYTES);

endpackage

// File: rtl/arb2_rr.sv
// Two-way arbiter, bit 1 = D, bit 0 = IF.
// With MEM_ARB_RR_EN it alternates on contention; otherwise D always wins.
module arb2_rr #(
  parameter bit RST_PRIO = 1'b1
) (
`ifdef MEM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

`ifdef MEM_ARB_RR_EN
  // r_ptr = 1 favours D; it only moves when both sides contend
  logic r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= RST_PRIO;
    end else if (&i_req) begin
      r_ptr <= ~r_ptr;
    end
  end

  always_comb begin
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt = r_ptr ? 2'b10 : 2'b01;
    end
  end
`else
  localparam bit unused_rst_prio = RST_PRIO;

  always_comb begin
    o_gnt = i_req;
    if (i_req[1]) begin
      o_gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and load/store.
// Build option: define MEM_ARB_RR_EN for round-robin, otherwise D has fixed priority.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int MEM_AW   = MEM_AW_DEF,
  parameter bit RST_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_dErr;
  logic       w_unused;

  owner_e r_owner;
  logic   r_err;
  logic   r_wr;

  // Requests are masked during reset so no grant or memory strobe leaks out
  assign w_req    = {d_req, if_req} & {2{rst_n}};
  assign w_dErr   = (d_addr[1:0] != 2'b00) || (d_addr[31:MEM_AW] != '0);
  assign w_unused = ^{if_addr[31:MEM_AW], if_addr[1:0]};

  arb2_rr #(
    .RST_PRIO(RST_PRIO)
  ) u_arb (
`ifdef MEM_ARB_RR_EN
    .clk  (clk),
    .rst_n(rst_n),
`endif
    .i_req(w_req),
    .o_gnt(w_gnt)
  );

  assign if_gnt = w_gnt[0];
  assign d_gnt  = w_gnt[1];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt && !w_dErr) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = {d_addr[MEM_AW-1:2], 2'b00};
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_be   = '1;
      mem_addr = {if_addr[MEM_AW-1:2], 2'b00};
    end
  end

  // Remembers who owns the memory response arriving next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
    end else if (d_gnt) begin
      r_owner <= OWN_D;
      r_err   <= w_dErr;
      r_wr    <= d_we;
    end else if (if_gnt) begin
      r_owner <= OWN_IF;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
    end
  end

  assign if_rvalid = (r_owner == OWN_IF);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rvalid  = (r_owner == OWN_D);
  assign d_err     = d_rvalid && r_err;
  assign d_rdata   = (d_rvalid && !r_err && !r_wr) ? mem_rdata : '0;

endmodule
